// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite single-port SRAM slave with programmable wait states and a two-cycle ERROR response.
// Handshake: an address phase is taken when HSEL & HREADY & HREADYOUT & HTRANS is NONSEQ/SEQ; a data phase ends on the edge where HREADYOUT=1.
module ahb_lite_sram_slave #(
  parameter int DATAWIDTH       = 32,
  parameter int ADDRWIDTH       = 32,
  parameter int SLAVE_ADDRWIDTH = 10,
  parameter int WAIT_STATES     = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HSEL,
  input  logic [ADDRWIDTH-1:0] HADDR,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [2:0]           HBURST,
  input  logic [1:0]           HTRANS,
  input  logic [DATAWIDTH-1:0] HWDATA,
  input  logic                 HREADY,
  output logic [DATAWIDTH-1:0] HRDATA,
  output logic                 HREADYOUT,
  output logic                 HRESP,
  output logic [1:0]           dbg_state
);
  localparam int DEPTH = 2 ** SLAVE_ADDRWIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_t;

  state_t                     state, state_n;
  logic [2:0]                 cnt, cnt_n;
  logic                       ph_valid;
  logic                       ph_write;
  logic [SLAVE_ADDRWIDTH-1:0] ph_idx;
  logic [3:0]                 ph_be;
  logic [DATAWIDTH-1:0]       rdata_q;
  logic [3:0]                 be;
  logic                       acc;
  logic                       illegal;
  logic                       we;
  logic                       rd_phase;
  logic                       unused_in;

  logic [DATAWIDTH-1:0] mem [0:DEPTH-1];

  assign unused_in = ^{HBURST, HTRANS[0]};

  assign HREADYOUT = (state == S_IDLE) || (state == S_ERR2);
  assign HRESP     = (state == S_ERR1) || (state == S_ERR2);
  assign dbg_state = state;

  assign acc     = HSEL && HREADY && HREADYOUT && HTRANS[1];
  assign illegal = (HSIZE > 3'd2)
                 || ((HSIZE == 3'd1) && HADDR[0])
                 || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))
                 || (HADDR[ADDRWIDTH-1:SLAVE_ADDRWIDTH+2] != '0);

  always_comb begin
    be = 4'b1111;
    case (HSIZE)
      3'd0:    be = 4'b0001 << HADDR[1:0];
      3'd1:    be = HADDR[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE, S_ERR2: begin
        state_n = S_IDLE;
        if (acc) begin
          if (illegal) begin
            state_n = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_n = S_WAIT;
            cnt_n   = 3'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        cnt_n = cnt - 3'd1;
        if (cnt == 3'd1) state_n = S_IDLE;
      end
      S_ERR1: state_n = S_ERR2;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      ph_valid <= 1'b0;
      ph_write <= 1'b0;
      ph_idx   <= '0;
      ph_be    <= '0;
      rdata_q  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rdata_q <= HRDATA;
      // The pending phase only advances when the current data phase ends; illegal ones never arm it.
      if (HREADYOUT) begin
        ph_valid <= acc && !illegal;
        if (acc) begin
          ph_write <= HWRITE;
          ph_idx   <= HADDR[SLAVE_ADDRWIDTH+1:2];
          ph_be    <= be;
        end
      end
    end
  end

  assign we       = ph_valid && ph_write && HREADYOUT;
  assign rd_phase = ph_valid && !ph_write && HREADYOUT;

  always_ff @(posedge HCLK) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (ph_be[i]) mem[ph_idx][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  // Asynchronous read: a write committed on one edge is visible to a read data phase in the next cycle.
  assign HRDATA = rd_phase ? mem[ph_idx] : rdata_q;

endmodule
